// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with architectural HI/LO registers
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide ops complete as no-ops.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV0,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_lo;
  logic [63:0] acc;
  logic [31:0] opnd;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [63:0] step_next;

  // Signed ops iterate on magnitudes; signs are restored in FIX.
  assign a_mag = (OP[0] && A[31]) ? (32'd0 - A) : A;
  assign b_mag = (OP[0] && B[31]) ? (32'd0 - B) : B;

  // acc holds {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign prod_fix = neg_lo ? (64'd0 - acc) : acc;

`ifdef MULDIV_DIV_EN
  logic        neg_hi;
  logic        zero_div;
  logic [31:0] a_raw;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
  assign quo_fix   = neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem_fix   = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
  assign step_next = is_div ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= 6'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DIV0   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
`ifdef MULDIV_DIV_EN
      neg_hi   <= 1'b0;
      zero_div <= 1'b0;
      a_raw    <= 32'd0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            BUSY   <= 1'b1;
            DIV0   <= 1'b0;
            cnt    <= 6'd0;
            is_div <= OP[1];
            neg_lo <= OP[0] & (A[31] ^ B[31]);
            opnd   <= OP[1] ? b_mag : a_mag;
            acc    <= OP[1] ? {32'd0, a_mag} : {32'd0, b_mag};
`ifdef MULDIV_DIV_EN
            neg_hi   <= OP[0] & A[31];
            zero_div <= (B == 32'd0);
            a_raw    <= A;
            state    <= ST_RUN;
`else
            state    <= OP[1] ? ST_FIX : ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          acc <= step_next;
          if (cnt == 6'd31) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          if (!is_div) begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
`ifdef MULDIV_DIV_EN
          else if (zero_div) begin
            HI   <= a_raw;
            LO   <= 32'hFFFF_FFFF;
            DIV0 <= 1'b1;
          end else begin
            HI <= rem_fix;
            LO <= quo_fix;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (both MULDIV_DIV_EN builds)
`timescale 1ns/1ps
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op_i), .A(a_i), .B(b_i),
    .BUSY(busy), .DONE(done), .DIV0(div0), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  // Reference model: arithmetic result computed at acceptance, released after the latency.
  logic        m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] p_res = 65'd0;
  int          remain = 0;

  function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, r;
    logic [63:0] p;
    if (op[1] && !DIV_EN) return {1'b0, cur_hi, cur_lo};
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b01: begin p = 64'(sa * sb); return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_div0 <= 1'b0;
      m_hi <= 32'd0; m_lo <= 32'd0; remain <= 0;
    end else begin
      m_done <= 1'b0;
      if (remain > 1) begin
        remain <= remain - 1;
      end else if (remain == 1) begin
        remain <= 0;
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_div0 <= p_res[64];
        m_hi   <= p_res[63:32];
        m_lo   <= p_res[31:0];
      end else if (start) begin
        p_res  <= ref_result(op_i, a_i, b_i, m_hi, m_lo);
        remain <= (op_i[1] && !DIV_EN) ? 1 : 33;
        m_busy <= 1'b1;
        m_div0 <= 1'b0;
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check1("cyc_busy", busy, m_busy);
    check1("cyc_done", done, m_done);
    check1("cyc_div0", div0, m_div0);
    check32("cyc_hi", hi, m_hi);
    check32("cyc_lo", lo, m_lo);
  end

  // Called at negedge+2; returns at negedge+2 of the cycle after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk); #2;
    start = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int poke,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 1;
    while (!done && n < 60) begin
      if (n == poke) begin
        start = 1'b1; op_i = 2'b10; a_i = 32'd99; b_i = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #2;
      n++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", name, n);
    end else begin
      check32({name, "_lat"}, 32'(n - 1), 32'(exp_lat));
      check32({name, "_hi"}, hi, exp_hi);
      check32({name, "_lo"}, lo, exp_lo);
    end
  endtask

  localparam int DLAT = DIV_EN ? 33 : 1;

  initial begin
    int ndone;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_div0", div0, 1'b0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33, 0, 32'hFFFF_FFFE, 32'h0000_0001);

    // Reset mid-run: immediate abort, no DONE afterwards
    issue(2'b00, 32'd3, 32'd5);
    repeat (9) begin @(negedge clk); #2; end
    rst = 1'b1;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); #2; if (done) ndone++; end
    check32("abort_no_done", 32'(ndone), 32'd0);

    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 33, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", DLAT, 0, DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFF,
              DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFEB);
    issue(2'b10, 32'd100, 32'd7);
    wait_done("divu_b2b", DLAT, 0, DIV_EN ? 32'd2 : 32'hFFFF_FFFF,
              DIV_EN ? 32'd14 : 32'hFFFF_FFEB);

    issue(2'b11, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negb", DLAT, 0, DIV_EN ? 32'd1 : 32'hFFFF_FFFF,
              DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFEB);

    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DLAT, 0, DIV_EN ? 32'd0 : 32'hFFFF_FFFF,
              DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFEB);
    check1("div_ovf_flag", div0, 1'b0);

    issue(2'b10, 32'h1234_5678, 32'd0);
    wait_done("divu_zero", DLAT, 0, DIV_EN ? 32'h1234_5678 : 32'hFFFF_FFFF,
              DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFEB);
    check1("div0_set", div0, DIV_EN);
    repeat (3) begin @(negedge clk); #2; end
    check1("div0_held", div0, DIV_EN);

    issue(2'b00, 32'd6, 32'd7);
    check1("div0_cleared", div0, 1'b0);
    check1("busy_after_start", busy, 1'b1);
    wait_done("multu_small", 33, 0, 32'd0, 32'd42);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1m1", 33, 0, 32'd0, 32'd1);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 33, 0, 32'h4000_0000, 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
